// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM for the 8-bit CPU: fetch, operand fetch, execute,
// halt/resume and a memory-wait timeout that aborts to HALT with bus_err.
module cpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       mem_ready,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       run,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       opnd_load,
  output logic       pc_en,
  output logic       sel_pc,
  output logic       sel_br,
  output logic [2:0] alu_op,
  output logic       acc_we,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_OPERAND = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_SKZ   = 4'h5;
  localparam logic [3:0] OP_SKC   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state, state_n;
  logic [7:0]    ir;
  logic [3:0]    opc;
  logic [CW-1:0] cnt, cnt_n;
  logic          timeout_hit;
  logic          ir_unused;

  assign opc       = ir[7:4];
  assign ir_unused = ir[3];
  assign state_dbg = state;

  // The wait counter only ever needs to reach MEM_TIMEOUT-1: the abort is
  // taken on the edge that ends the MEM_TIMEOUT-th waiting cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                       (32'(cnt) == MEM_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_BOOT;
      ir      <= '0;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ir_load) ir <= instr;
      if (timeout_hit) bus_err <= 1'b1;
      else if (state == S_HALT && run) bus_err <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_BOOT:  state_n = S_FETCH;
      S_FETCH: if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_ALU:                   state_n = S_EXEC;
          OP_LOAD, OP_STORE, OP_JMP: state_n = S_OPERAND;
          OP_HALT:                  state_n = S_HALT;
          default:                  state_n = S_FETCH;
        endcase
      end
      S_OPERAND: if (mem_ready) state_n = S_EXEC;
      S_EXEC: begin
        if ((opc == OP_LOAD || opc == OP_STORE) && !mem_ready) state_n = S_EXEC;
        else state_n = S_FETCH;
      end
      S_HALT:  if (run) state_n = S_FETCH;
      default: state_n = S_BOOT;
    endcase
    if (timeout_hit) state_n = S_HALT;
  end

  always_comb begin
    if (state_n != state || mem_ready || !mem_req) cnt_n = '0;
    else cnt_n = cnt + CW'(1);
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    opnd_load = 1'b0;
    pc_en     = 1'b0;
    sel_pc    = 1'b0;
    sel_br    = 1'b0;
    alu_op    = 3'd0;
    acc_we    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_en   = mem_ready;
      end
      S_DECODE: begin
        case (opc)
          OP_SKZ: begin
            pc_en  = zero_flag;
            sel_br = zero_flag;
          end
          OP_SKC: begin
            pc_en  = carry_flag;
            sel_br = carry_flag;
          end
          OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_JMP, OP_HALT: ;
          default: illegal = 1'b1;
        endcase
      end
      S_OPERAND: begin
        mem_req   = 1'b1;
        opnd_load = mem_ready;
        pc_en     = mem_ready;
      end
      S_EXEC: begin
        case (opc)
          OP_ALU: begin
            acc_we = 1'b1;
            alu_op = ir[2:0];
          end
          OP_LOAD: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            acc_we   = mem_ready;
          end
          OP_STORE: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_sel = 1'b1;
          end
          OP_JMP: begin
            pc_en  = 1'b1;
            sel_pc = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: an instruction-level model expands random programs
// into per-cycle stimulus and expected outputs, replayed against the DUT.
module tb_cpu_ctrl;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       mem_ready, zero_flag, carry_flag, run;
  logic       mem_req, mem_we, addr_sel, ir_load, opnd_load, pc_en;
  logic       sel_pc, sel_br, acc_we, halted, illegal, bus_err;
  logic [2:0] alu_op;
  logic [2:0] state_dbg;

  cpu_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .opnd_load(opnd_load), .pc_en(pc_en),
    .sel_pc(sel_pc), .sel_br(sel_br), .alu_op(alu_op), .acc_we(acc_we),
    .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_load, opnd_load, pc_en, sel_pc, sel_br;
    logic [2:0] alu_op;
    logic       acc_we, halted, illegal, bus_err;
  } outs_t;

  typedef struct packed {
    logic [7:0] instr;
    logic       rdy, zf, cf, run;
  } stim_t;

  outs_t got;
  assign got = {mem_req, mem_we, addr_sel, ir_load, opnd_load, pc_en, sel_pc,
                sel_br, alu_op, acc_we, halted, illegal, bus_err};

  // Program counter and operand register as the datapath would hold them.
  logic [7:0] tb_pc, tb_opnd;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tb_pc   <= 8'd0;
      tb_opnd <= 8'd0;
    end else begin
      if (pc_en) tb_pc <= sel_pc ? tb_opnd : (sel_br ? tb_pc + 8'd2 : tb_pc + 8'd1);
      if (opnd_load) tb_opnd <= instr;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  stim_t       stim_q[$];
  logic [22:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got_v, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_pc, m_opnd;
  bit         m_err, m_halt;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic int rdelay();
    int r = $urandom_range(0, 19);
    return (r < 17) ? (r % 4) : $urandom_range(4, 6);
  endfunction

  function automatic logic [7:0] rand_op();
    int pick = $urandom_range(0, 9);
    logic [3:0] code;
    if (pick <= 6) code = 4'(pick);
    else if (pick == 7) code = 4'hF;
    else code = 4'($urandom_range(7, 14));
    return {code, 4'($urandom_range(0, 15))};
  endfunction

  task automatic push(input outs_t o, input logic [7:0] iv, input logic rdy,
                      input logic zf, input logic cf, input logic rv);
    o.bus_err = m_err;
    stim_q.push_back({iv, rdy, zf, cf, rv});
    exp_q.push_back({m_pc, o});
    if (o.pc_en) m_pc = o.sel_pc ? m_opnd : (o.sel_br ? m_pc + 8'd2 : m_pc + 8'd1);
    if (o.opnd_load) m_opnd = iv;
  endtask

  // One memory access: `delay` waiting cycles, then completion, unless the
  // wait runs out first, in which case the CPU ends up halted with bus_err.
  task automatic mem_access(input outs_t base, input outs_t done, input logic [7:0] data,
                            input int delay, output bit ok);
    outs_t bd;
    ok = 1'b1;
    for (int i = 0; i < delay; i++) begin
      push(base, rbyte(), 1'b0, rbit(), rbit(), rbit());
      if (i == int'(TO) - 1) begin
        m_err  = 1'b1;
        m_halt = 1'b1;
        ok     = 1'b0;
        return;
      end
    end
    bd = base | done;
    push(bd, data, 1'b1, rbit(), rbit(), rbit());
  endtask

  task automatic halt_seq();
    outs_t o;
    o = '0;
    o.halted = 1'b1;
    repeat ($urandom_range(0, 2)) push(o, rbyte(), rbit(), rbit(), rbit(), 1'b0);
    push(o, rbyte(), rbit(), rbit(), rbit(), 1'b1);
    m_err  = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic instr_seq(input logic [7:0] op, input int fd, input logic [7:0] opnd,
                           input int od, input int ed, input logic zf, input logic cf);
    outs_t b, d;
    bit ok;
    logic [3:0] code;
    code = op[7:4];
    b = '0; b.mem_req = 1'b1;
    d = '0; d.ir_load = 1'b1; d.pc_en = 1'b1;
    mem_access(b, d, op, fd, ok);
    if (ok) begin
      d = '0;
      case (code)
        4'h5: begin d.pc_en = zf; d.sel_br = zf; end
        4'h6: begin d.pc_en = cf; d.sel_br = cf; end
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF: ;
        default: d.illegal = 1'b1;
      endcase
      push(d, rbyte(), rbit(), zf, cf, rbit());
      if (code == 4'hF) m_halt = 1'b1;
      if (code inside {4'h2, 4'h3, 4'h4}) begin
        b = '0; b.mem_req = 1'b1;
        d = '0; d.opnd_load = 1'b1; d.pc_en = 1'b1;
        mem_access(b, d, opnd, od, ok);
      end
      if (ok) begin
        b = '0; d = '0;
        case (code)
          4'h1: begin
            d.acc_we = 1'b1; d.alu_op = op[2:0];
            push(d, rbyte(), rbit(), rbit(), rbit(), rbit());
          end
          4'h2: begin
            b.mem_req = 1'b1; b.addr_sel = 1'b1; d.acc_we = 1'b1;
            mem_access(b, d, rbyte(), ed, ok);
          end
          4'h3: begin
            b.mem_req = 1'b1; b.mem_we = 1'b1; b.addr_sel = 1'b1;
            mem_access(b, d, rbyte(), ed, ok);
          end
          4'h4: begin
            d.pc_en = 1'b1; d.sel_pc = 1'b1;
            push(d, rbyte(), rbit(), rbit(), rbit(), rbit());
          end
          default: ;
        endcase
      end
    end
    if (m_halt) halt_seq();
  endtask

  // ---------------- driver / main ----------------
  task automatic drive(input stim_t s);
    instr      = s.instr;
    mem_ready  = s.rdy;
    zero_flag  = s.zf;
    carry_flag = s.cf;
    run        = s.run;
  endtask

  initial begin
    outs_t z;
    stim_t s;
    logic [22:0] e;
    z = '0;
    m_pc = 8'd0; m_opnd = 8'd0; m_err = 1'b0; m_halt = 1'b0;
    reset = 1'b0;
    drive({8'h13, 1'b1, 1'b0, 1'b0, 1'b1});

    repeat (3) begin
      @(negedge clk);
      drive({rbyte(), 1'b1, rbit(), rbit(), rbit()});
      #1;
      check_eq("reset_outs", 32'(got), 32'(z));
    end

    push(z, rbyte(), 1'b1, rbit(), rbit(), 1'b1);         // BOOT cycle
    instr_seq(8'h13, 0, 8'h00, 0, 0, 1'b0, 1'b0);          // ALU op 3
    instr_seq(8'h40, 0, 8'h5A, 0, 0, 1'b0, 1'b0);          // JMP 0x5A
    instr_seq(8'h50, 1, 8'h00, 0, 0, 1'b1, 1'b0);          // SKZ taken
    instr_seq(8'h50, 0, 8'h00, 0, 0, 1'b0, 1'b1);          // SKZ not taken
    instr_seq(8'h60, 0, 8'h00, 0, 0, 1'b0, 1'b1);          // SKC taken
    instr_seq(8'h35, 0, 8'h20, 2, 3, 1'b0, 1'b0);          // STORE, slow memory
    instr_seq(8'h27, 0, 8'h21, 1, 2, 1'b1, 1'b1);          // LOAD
    instr_seq(8'h00, int'(TO), 8'h00, 0, 0, 1'b0, 1'b0);   // fetch timeout
    instr_seq(8'h90, 0, 8'h00, 0, 0, 1'b0, 1'b0);          // illegal
    instr_seq(8'hF0, 0, 8'h00, 0, 0, 1'b0, 1'b0);          // HALT then run
    instr_seq(8'h20, 0, 8'h33, 5, 0, 1'b0, 1'b0);          // operand timeout
    instr_seq(8'h30, 0, 8'h44, 0, 7, 1'b0, 1'b0);          // store timeout
    repeat (300) instr_seq(rand_op(), rdelay(), rbyte(), rdelay(), rdelay(), rbit(), rbit());
    begin
      outs_t b;
      b = '0; b.mem_req = 1'b1;
      push(b, rbyte(), 1'b0, 1'b0, 1'b0, 1'b0);            // left waiting in FETCH
    end

    while (stim_q.size() > 0) begin
      @(negedge clk);
      reset = 1'b1;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      drive(s);
      #1;
      check_eq("outs", 32'(got), 32'(e[14:0]));
      check_eq("pc", 32'(tb_pc), 32'(e[22:15]));
    end

    #1 reset = 1'b0;
    #1 check_eq("reset_mid_wait", 32'(got), 32'(z));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
